// File: rtl/axi_rd_arb.sv
// Two-requester round-robin arbiter for a single AXI read master.
// One burst outstanding at a time; R beats are routed to the owner and checked for integrity.
module axi_rd_arb #(
  parameter int AWID_WIDTH   = 4,
  parameter int AWADDR_WIDTH = 32,
  parameter int WDATA_WIDTH  = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0_arvalid,
  input  logic [AWADDR_WIDTH-1:0] req0_araddr,
  input  logic [7:0]              req0_arlen,
  output logic                    req0_arready,
  output logic                    req0_rvalid,
  output logic [WDATA_WIDTH-1:0]  req0_rdata,
  output logic [1:0]              req0_rresp,
  output logic                    req0_rlast,
  input  logic                    req0_rready,
  input  logic                    req1_arvalid,
  input  logic [AWADDR_WIDTH-1:0] req1_araddr,
  input  logic [7:0]              req1_arlen,
  output logic                    req1_arready,
  output logic                    req1_rvalid,
  output logic [WDATA_WIDTH-1:0]  req1_rdata,
  output logic [1:0]              req1_rresp,
  output logic                    req1_rlast,
  input  logic                    req1_rready,
  output logic [AWID_WIDTH-1:0]   ARID,
  output logic [AWADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]              ARLEN,
  output logic [2:0]              ARSIZE,
  output logic [1:0]              ARBURST,
  output logic [3:0]              ARREGION,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [AWID_WIDTH-1:0]   RID,
  input  logic [WDATA_WIDTH-1:0]  RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RLAST,
  input  logic                    RVALID,
  output logic                    RREADY,
  output logic                    busy,
  output logic                    err
);

  localparam int SIZE_I = $clog2(WDATA_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                  state_q, state_d;
  logic                    rr_q, rr_d;
  logic                    owner_q, owner_d;
  logic                    err_q, err_d;
  logic [AWADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    gnt0, gnt1;
  logic                    owner_rready;
  logic                    r_hs;
  logic                    route0, route1;
  logic [AWID_WIDTH-1:0]   owner_id;

  // A lone requester wins outright; rr only breaks ties.
  assign gnt0 = req0_arvalid & (~req1_arvalid | ~rr_q);
  assign gnt1 = req1_arvalid & (~req0_arvalid | rr_q);

  assign owner_id     = {{(AWID_WIDTH-1){1'b0}}, owner_q};
  assign owner_rready = owner_q ? req1_rready : req0_rready;

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    owner_d      = owner_q;
    err_d        = err_q;
    addr_d       = addr_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    req0_arready = 1'b0;
    req1_arready = 1'b0;
    RREADY       = 1'b0;
    r_hs         = 1'b0;
    case (state_q)
      IDLE: begin
        // No burst is open, so any R beat here is unsolicited.
        if (RVALID) err_d = 1'b1;
        if (gnt0 | gnt1) begin
          req0_arready = gnt0;
          req1_arready = gnt1;
          owner_d      = gnt1;
          rr_d         = ~gnt1;
          addr_d       = gnt1 ? req1_araddr : req0_araddr;
          len_d        = gnt1 ? req1_arlen : req0_arlen;
          state_d      = ADDR;
        end
      end
      ADDR: begin
        if (ARREADY) begin
          cnt_d   = 8'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        RREADY = owner_rready;
        r_hs   = RVALID & owner_rready;
        if (r_hs) begin
          cnt_d = cnt_q + 8'd1;
          if (RID != owner_id) err_d = 1'b1;
          if (RLAST && (cnt_q != len_q)) err_d = 1'b1;
          // A missing RLAST at the expected last beat, or a counter about to wrap.
          if (!RLAST && ((cnt_q == len_q) || (cnt_q == 8'hff))) err_d = 1'b1;
          if (RLAST) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  assign route0 = (state_q == DATA) & ~owner_q;
  assign route1 = (state_q == DATA) & owner_q;

  assign req0_rvalid = route0 & RVALID;
  assign req0_rdata  = route0 ? RDATA : '0;
  assign req0_rresp  = route0 ? RRESP : 2'b00;
  assign req0_rlast  = route0 & RLAST;
  assign req1_rvalid = route1 & RVALID;
  assign req1_rdata  = route1 ? RDATA : '0;
  assign req1_rresp  = route1 ? RRESP : 2'b00;
  assign req1_rlast  = route1 & RLAST;

  assign ARVALID  = (state_q == ADDR);
  assign ARID     = owner_id;
  assign ARADDR   = addr_q;
  assign ARLEN    = len_q;
  assign ARSIZE   = 3'(SIZE_I);
  assign ARBURST  = 2'b01;
  assign ARREGION = 4'd0;
  assign busy     = (state_q != IDLE);
  assign err      = err_q;

endmodule

// File: tb/tb_axi_rd_arb.sv
// Bench for axi_rd_arb: directed cycle table for the corner cases, then
// random traffic against a transaction-level model of the arbiter and slave.
module tb_axi_rd_arb;
  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         req0_arvalid, req1_arvalid;
  logic [31:0]  req0_araddr, req1_araddr;
  logic [7:0]   req0_arlen, req1_arlen;
  logic         req0_arready, req1_arready;
  logic         req0_rvalid, req1_rvalid;
  logic [127:0] req0_rdata, req1_rdata;
  logic [1:0]   req0_rresp, req1_rresp;
  logic         req0_rlast, req1_rlast;
  logic         req0_rready, req1_rready;
  logic [3:0]   ARID;
  logic [31:0]  ARADDR;
  logic [7:0]   ARLEN;
  logic [2:0]   ARSIZE;
  logic [1:0]   ARBURST;
  logic [3:0]   ARREGION;
  logic         ARVALID, ARREADY;
  logic [3:0]   RID;
  logic [127:0] RDATA;
  logic [1:0]   RRESP;
  logic         RLAST, RVALID, RREADY;
  logic         busy, err;

  int checks = 0;
  int errors = 0;

  axi_rd_arb #(.AWID_WIDTH(4), .AWADDR_WIDTH(32), .WDATA_WIDTH(128)) dut (
    .clk(clk), .rst(rst),
    .req0_arvalid(req0_arvalid), .req0_araddr(req0_araddr), .req0_arlen(req0_arlen),
    .req0_arready(req0_arready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req0_rresp(req0_rresp), .req0_rlast(req0_rlast), .req0_rready(req0_rready),
    .req1_arvalid(req1_arvalid), .req1_araddr(req1_araddr), .req1_arlen(req1_arlen),
    .req1_arready(req1_arready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .req1_rresp(req1_rresp), .req1_rlast(req1_rlast), .req1_rready(req1_rready),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARREGION(ARREGION), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .busy(busy), .err(err)
  );

  task automatic chk(input string nm, input int idx, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  // One row = one clock: inputs applied, then outputs expected in that same cycle.
  typedef struct {
    bit rs, r0v, r1v; bit [7:0] l0, l1; bit arrdy, rv, rl; bit [3:0] rid; bit y0, y1;
    bit a0, a1, arv; bit [3:0] arid; bit [7:0] elen; bit rrdy, v0, v1, bsy, er;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(int rs, int r0v, int r1v, int l0, int l1, int arrdy,
                              int rv, int rl, int rid, int y0, int y1,
                              int a0, int a1, int arv, int arid, int elen,
                              int rrdy, int v0, int v1, int bsy, int er);
    vec_t v;
    v.rs = (rs != 0); v.r0v = (r0v != 0); v.r1v = (r1v != 0);
    v.l0 = 8'(l0); v.l1 = 8'(l1); v.arrdy = (arrdy != 0);
    v.rv = (rv != 0); v.rl = (rl != 0); v.rid = 4'(rid); v.y0 = (y0 != 0); v.y1 = (y1 != 0);
    v.a0 = (a0 != 0); v.a1 = (a1 != 0); v.arv = (arv != 0); v.arid = 4'(arid);
    v.elen = 8'(elen); v.rrdy = (rrdy != 0); v.v0 = (v0 != 0); v.v1 = (v1 != 0);
    v.bsy = (bsy != 0); v.er = (er != 0);
    tbl.push_back(v);
  endfunction

  task automatic clear_inputs();
    req0_arvalid = 0; req1_arvalid = 0; req0_araddr = 0; req1_araddr = 0;
    req0_arlen = 0; req1_arlen = 0; req0_rready = 0; req1_rready = 0;
    ARREADY = 0; RID = 0; RDATA = 0; RRESP = 0; RLAST = 0; RVALID = 0;
  endtask

  task automatic apply(input vec_t v, input int i);
    rst = v.rs;
    req0_arvalid = v.r0v; req1_arvalid = v.r1v;
    req0_arlen = v.l0; req1_arlen = v.l1;
    // Addresses are only meaningful on the grant cycle; otherwise scramble them.
    req0_araddr = v.a0 ? 32'h100 : $urandom;
    req1_araddr = v.a1 ? 32'h200 : $urandom;
    ARREADY = v.arrdy; RVALID = v.rv; RLAST = v.rl; RID = v.rid;
    RDATA = {$urandom, $urandom, $urandom, $urandom}; RRESP = 2'(i);
    req0_rready = v.y0; req1_rready = v.y1;
    #1;
    chk("arready0", i, 128'(req0_arready), 128'(v.a0));
    chk("arready1", i, 128'(req1_arready), 128'(v.a1));
    chk("arvalid", i, 128'(ARVALID), 128'(v.arv));
    if (v.arv) begin
      chk("arid", i, 128'(ARID), 128'(v.arid));
      chk("araddr", i, 128'(ARADDR), (v.arid == 4'd1) ? 128'h200 : 128'h100);
      chk("arlen", i, 128'(ARLEN), 128'(v.elen));
    end
    chk("rready", i, 128'(RREADY), 128'(v.rrdy));
    chk("rvalid0", i, 128'(req0_rvalid), 128'(v.v0));
    chk("rvalid1", i, 128'(req1_rvalid), 128'(v.v1));
    if (v.v0) begin
      chk("rdata0", i, req0_rdata, RDATA);
      chk("rresp0", i, 128'(req0_rresp), 128'(RRESP));
      chk("rlast0", i, 128'(req0_rlast), 128'(RLAST));
      chk("rdata1_idle", i, req1_rdata, 128'd0);
    end
    if (v.v1) begin
      chk("rdata1", i, req1_rdata, RDATA);
      chk("rresp1", i, 128'(req1_rresp), 128'(RRESP));
      chk("rlast1", i, 128'(req1_rlast), 128'(RLAST));
      chk("rdata0_idle", i, req0_rdata, 128'd0);
    end
    chk("busy", i, 128'(busy), 128'(v.bsy));
    chk("err", i, 128'(err), 128'(v.er));
  endtask

  // Random-phase state: requesters, slave, and the reference model.
  bit           p0, p1;
  logic [31:0]  pa0, pa1;
  logic [7:0]   pl0, pl1;
  bit           m_busy, m_arp, m_own, m_rr;
  logic [31:0]  m_addr;
  logic [7:0]   m_len;
  int           got;
  int           bursts_done;
  bit           s_act, rv_h;
  logic [3:0]   s_id;
  logic [7:0]   s_len, s_beat;
  logic [127:0] rd_h;

  initial begin
    rst = 1; clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 0; #1;
    chk("rst_arvalid", 0, 128'(ARVALID), 128'd0);
    chk("rst_araddr", 0, 128'(ARADDR), 128'd0);
    chk("rst_arlen", 0, 128'(ARLEN), 128'd0);
    chk("rst_arid", 0, 128'(ARID), 128'd0);
    chk("rst_busy", 0, 128'(busy), 128'd0);
    chk("rst_err", 0, 128'(err), 128'd0);
    chk("arsize", 0, 128'(ARSIZE), 128'd4);
    chk("arburst", 0, 128'(ARBURST), 128'd1);
    chk("arregion", 0, 128'(ARREGION), 128'd0);

    // Single req0 burst, len=3.
    add(0,1,0,3,0,0, 0,0,0,0,0, 1,0,0,0,0, 0,0,0,0,0);
    add(0,0,0,0,0,1, 0,0,0,0,0, 0,0,1,0,3, 0,0,0,1,0);
    for (int b = 0; b < 4; b++) add(0,0,0,0,0,0, 1,(b==3),0,1,0, 0,0,0,0,0, 1,1,0,1,0);
    add(0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0);
    // Contention: alternating grants from a fresh rr.
    add(1,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0);
    for (int k = 0; k < 4; k++) begin
      add(0,1,1,0,0,0, 0,0,0,0,0, (k%2==0),(k%2==1),0,0,0, 0,0,0,0,0);
      add(0,1,1,0,0,1, 0,0,0,0,0, 0,0,1,k%2,0, 0,0,0,1,0);
      add(0,1,1,0,0,0, 1,1,k%2,1,1, 0,0,0,0,0, 1,(k%2==0),(k%2==1),1,0);
    end
    // Backpressure: req1 len=7, ARREADY late, rready toggling.
    add(0,0,1,0,7,0, 0,0,0,0,0, 0,1,0,0,0, 0,0,0,0,0);
    for (int w = 0; w < 5; w++) add(0,0,0,0,0,0, 0,0,0,0,0, 0,0,1,1,7, 0,0,0,1,0);
    add(0,0,0,0,0,1, 0,0,0,0,0, 0,0,1,1,7, 0,0,0,1,0);
    for (int k = 0; k < 16; k++) add(0,0,0,0,0,0, 1,(k>=14),1,1,k%2, 0,0,0,0,0, k%2,0,1,1,0);
    add(0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0);
    // Early RLAST, then a normal burst with err sticky.
    add(0,1,0,3,0,0, 0,0,0,0,0, 1,0,0,0,0, 0,0,0,0,0);
    add(0,0,0,0,0,1, 0,0,0,0,0, 0,0,1,0,3, 0,0,0,1,0);
    for (int b = 0; b < 3; b++) add(0,0,0,0,0,0, 1,(b==2),0,1,0, 0,0,0,0,0, 1,1,0,1,0);
    add(0,1,0,0,0,0, 0,0,0,0,0, 1,0,0,0,0, 0,0,0,0,1);
    add(0,0,0,0,0,1, 0,0,0,0,0, 0,0,1,0,0, 0,0,0,1,1);
    add(0,0,0,0,0,0, 1,1,0,1,0, 0,0,0,0,0, 1,1,0,1,1);
    add(0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,1);
    add(1,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,1);
    // Wrong RID on owner 0.
    add(0,1,0,1,0,0, 0,0,0,0,0, 1,0,0,0,0, 0,0,0,0,0);
    add(0,0,0,0,0,1, 0,0,0,0,0, 0,0,1,0,1, 0,0,0,1,0);
    add(0,0,0,0,0,0, 1,0,1,1,0, 0,0,0,0,0, 1,1,0,1,0);
    add(0,0,0,0,0,0, 1,1,0,1,0, 0,0,0,0,0, 1,1,0,1,1);
    add(0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,1);
    add(1,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,1);
    // Unsolicited beat while idle.
    add(0,0,0,0,0,0, 1,0,0,1,1, 0,0,0,0,0, 0,0,0,0,0);
    add(0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,1);
    add(1,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,1);
    // Reset after two beats of a req0 burst.
    add(0,1,0,3,0,0, 0,0,0,0,0, 1,0,0,0,0, 0,0,0,0,0);
    add(0,0,0,0,0,1, 0,0,0,0,0, 0,0,1,0,3, 0,0,0,1,0);
    for (int b = 0; b < 2; b++) add(0,0,0,0,0,0, 1,0,0,1,0, 0,0,0,0,0, 1,1,0,1,0);
    add(1,0,0,0,0,0, 1,0,0,1,0, 0,0,0,0,0, 1,1,0,1,0);
    add(0,1,1,0,0,0, 0,0,0,1,0, 1,0,0,0,0, 0,0,0,0,0);
    add(0,1,1,0,0,1, 0,0,0,0,0, 0,0,1,0,0, 0,0,0,1,0);
    add(0,1,1,0,0,0, 1,1,0,1,0, 0,0,0,0,0, 1,1,0,1,0);
    add(0,1,1,0,0,0, 0,0,0,0,0, 0,1,0,0,0, 0,0,0,0,0);
    add(0,0,0,0,0,1, 0,0,0,0,0, 0,0,1,1,0, 0,0,0,1,0);
    add(0,0,0,0,0,0, 1,1,1,0,1, 0,0,0,0,0, 1,0,1,1,0);
    add(0,0,1,0,0,0, 0,0,0,0,0, 0,1,0,0,0, 0,0,0,0,0);
    add(0,0,0,0,0,1, 0,0,0,0,0, 0,0,1,1,0, 0,0,0,1,0);
    add(0,0,0,0,0,0, 1,1,1,0,1, 0,0,0,0,0, 1,0,1,1,0);
    add(0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      apply(tbl[i], i);
    end

    // Random traffic against the model.
    @(posedge clk); #1;
    rst = 1; clear_inputs();
    @(posedge clk); #1;
    rst = 0;
    p0 = 0; p1 = 0; pa0 = 0; pa1 = 0; pl0 = 0; pl1 = 0;
    m_busy = 0; m_arp = 0; m_own = 0; m_rr = 0; m_addr = 0; m_len = 0;
    got = 0; bursts_done = 0; s_act = 0; rv_h = 0; s_id = 0; s_len = 0; s_beat = 0; rd_h = 0;
    for (int c = 0; c < 3000; c++) begin
      bit g0, g1, dph, ordy, hs;
      @(posedge clk); #1;
      if (!p0 && $urandom_range(0, 2) == 0) begin p0 = 1; pa0 = $urandom; pl0 = 8'($urandom_range(0, 7)); end
      if (!p1 && $urandom_range(0, 2) == 0) begin p1 = 1; pa1 = $urandom; pl1 = 8'($urandom_range(0, 7)); end
      req0_arvalid = p0; req0_araddr = pa0; req0_arlen = pl0;
      req1_arvalid = p1; req1_araddr = pa1; req1_arlen = pl1;
      req0_rready = ($urandom_range(0, 3) != 0);
      req1_rready = ($urandom_range(0, 3) != 0);
      ARREADY = $urandom_range(0, 1) != 0;
      if (s_act && !rv_h && $urandom_range(0, 2) != 0) begin
        rv_h = 1; rd_h = {$urandom, $urandom, $urandom, $urandom};
      end
      RVALID = rv_h; RDATA = rd_h; RID = s_id; RRESP = s_beat[1:0];
      RLAST = rv_h && (s_beat == s_len);
      #1;
      g0 = !m_busy && p0 && (!p1 || !m_rr);
      g1 = !m_busy && p1 && (!p0 || m_rr);
      dph = m_busy && !m_arp;
      ordy = m_own ? req1_rready : req0_rready;
      chk("r_arready0", c, 128'(req0_arready), 128'(g0));
      chk("r_arready1", c, 128'(req1_arready), 128'(g1));
      chk("r_arvalid", c, 128'(ARVALID), 128'(m_arp));
      if (m_arp) begin
        chk("r_araddr", c, 128'(ARADDR), 128'(m_addr));
        chk("r_arlen", c, 128'(ARLEN), 128'(m_len));
        chk("r_arid", c, 128'(ARID), 128'(m_own));
      end
      chk("r_rready", c, 128'(RREADY), 128'(dph && ordy));
      chk("r_rvalid0", c, 128'(req0_rvalid), 128'(dph && !m_own && RVALID));
      chk("r_rvalid1", c, 128'(req1_rvalid), 128'(dph && m_own && RVALID));
      if (dph && RVALID) chk("r_rdata", c, m_own ? req1_rdata : req0_rdata, RDATA);
      chk("r_busy", c, 128'(busy), 128'(m_busy));
      chk("r_err", c, 128'(err), 128'd0);
      hs = dph && RVALID && ordy;
      if (hs) begin
        got++;
        if (RLAST) begin
          chk("r_burst_beats", c, 128'(got), 128'(m_len) + 128'd1);
          got = 0; m_busy = 0; s_act = 0; bursts_done++;
        end
        s_beat = s_beat + 8'd1; rv_h = 0;
      end
      if (m_arp && ARREADY) begin
        m_arp = 0; s_act = 1; s_id = 4'(m_own); s_len = m_len; s_beat = 0;
      end
      if (g0 || g1) begin
        m_busy = 1; m_arp = 1; m_own = g1; m_rr = !g1;
        m_addr = g1 ? pa1 : pa0; m_len = g1 ? pl1 : pl0;
        if (g1) p1 = 0; else p0 = 0;
      end
    end
    chk("r_bursts_seen", 0, 128'(bursts_done > 100), 128'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
